core_seq: RTL and testbench

//  Multi-cycle instruction sequencer for the RV32I core. It steps each instruction through

---
 rtl/core_seq_if.sv | 11 +
 rtl/core_seq.sv | 168 ++++++++++++++++
 tb/tb_core_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_if.sv
// Shared memory-port handshake between the sequencer (master) and the
// memory subsystem (slave). The request is held until the ack cycle.
interface core_seq_if;
   logic mem_req;   // request, held until mem_ack
   logic mem_data;  // 0 = instruction fetch, 1 = data access
   logic mem_we;    // 1 = store
   logic mem_ack;   // memory completes the current request this cycle

   modport master (output mem_req, output mem_data, output mem_we, input mem_ack);
   modport slave  (input mem_req, input mem_data, input mem_we, output mem_ack);
endinterface

// File: rtl/core_seq.sv
// core_seq: multi-cycle RV32I instruction sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the IR,
// PC and register-file strobes and owns the shared memory request.
// Outputs are decoded from the current state, qualified by mem_ack where a
// memory transfer completes.
// Optional feature macro: CORE_SEQ_PERF_EN enables the cycle and retired
// instruction counters; when undefined the counter ports are tied to zero.
module core_seq #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_branch,
   input  logic             is_jmp,
   input  logic             rd_w,
   input  logic             illegal,
   input  logic             br_taken,
   input  logic             halt_req,
   core_seq_if.master       bus,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             rf_we,
   output logic             retire,
   output logic             halted,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd7
   } state_e;

   state_e state_q;
   state_e state_d;
   state_e boundary_s;

   // After a retiring transition the sequencer parks in IDLE on a debug stop.
   assign boundary_s = halt_req ? IDLE : FETCH;

   // State register; reset abandons any in-flight memory request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode; every strobe defaults low.
   always_comb begin
      state_d      = state_q;
      bus.mem_req  = 1'b0;
      bus.mem_data = 1'b0;
      bus.mem_we   = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      rf_we        = 1'b0;
      retire       = 1'b0;
      halted       = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = boundary_s;
         end
         FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack) begin
               ir_we   = 1'b1;
               state_d = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            // Conflicting load+store flags are treated like an illegal opcode.
            if (illegal || (is_load && is_store)) begin
               state_d = HALT;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (is_load || is_store) begin
               state_d = MEM;
            end else if (rd_w) begin
               state_d = WB;
            end else begin
               pc_we   = 1'b1;
               pc_sel  = is_branch & br_taken;
               retire  = 1'b1;
               state_d = boundary_s;
            end
         end
         MEM: begin
            bus.mem_req  = 1'b1;
            bus.mem_data = 1'b1;
            bus.mem_we   = is_store;
            if (bus.mem_ack) begin
               if (is_store) begin
                  pc_we   = 1'b1;
                  pc_sel  = 1'b0;
                  retire  = 1'b1;
                  state_d = boundary_s;
               end else begin
                  state_d = WB;
               end
            end else begin
               state_d = MEM;
            end
         end
         WB: begin
            // A load with rd_w=0 still passes through WB without writing.
            rf_we   = rd_w;
            pc_we   = 1'b1;
            pc_sel  = is_jmp;
            retire  = 1'b1;
            state_d = boundary_s;
         end
         HALT: begin
            halted  = 1'b1;
            state_d = HALT;
         end
         default: begin
            // Unreachable encodings stop the core rather than guess.
            state_d = HALT;
         end
      endcase
   end

   assign state = state_q;

`ifdef CORE_SEQ_PERF_EN
   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] instret_cnt_q;

   // Free-running perf counters, wrapping naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (retire) begin
            instret_cnt_q <= instret_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            instret_cnt_q <= instret_cnt_q;
         end
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: a table of instruction records with
// expected per-instruction results pushed to a scoreboard, plus hand-written
// sequences for reset, halt, illegal opcode and reset-during-MEM.
module tb_core_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jmp = 1'b0;
   logic        rd_w = 1'b0, illegal = 1'b0, br_taken = 1'b0, halt_req = 1'b0;
   logic        ir_we, pc_we, pc_sel, rf_we, retire, halted;
   logic [2:0]  state;
   logic [31:0] cycle_cnt, instret_cnt;

   core_seq_if bus ();

   core_seq #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .is_load(is_load), .is_store(is_store),
      .is_branch(is_branch), .is_jmp(is_jmp), .rd_w(rd_w), .illegal(illegal),
      .br_taken(br_taken), .halt_req(halt_req), .bus(bus),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
      .retire(retire), .halted(halted), .state(state),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      logic  ld, st, br, jmp, rdw, tkn, stray;
      int    fw, mw;
      int    cyc, rf, psel, dreq, dwe;
   } vec_t;

   vec_t vecs[10];
   vec_t sb[$];

   int errors = 0;
   int checks = 0;
   int fw_cur = 0, mw_cur = 0, req_cnt = 0;
   logic stray_cur = 1'b0;
   int m_cyc = 0, m_ir = 0;
   logic s_req, s_data, s_we, s_irw, s_pcwe, s_psel, s_rfwe, s_ret;
   logic [2:0] s_state;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: drive mem_ack at negedge, sample outputs, step the edge.
   task automatic cyc();
      @(negedge clk);
      if (bus.mem_req) begin
         bus.mem_ack = (req_cnt >= (bus.mem_data ? mw_cur : fw_cur));
      end else begin
         bus.mem_ack = stray_cur;
      end
      #1;
      s_req = bus.mem_req; s_data = bus.mem_data; s_we = bus.mem_we;
      s_irw = ir_we; s_pcwe = pc_we; s_psel = pc_sel; s_rfwe = rf_we;
      s_ret = retire; s_state = state;
      if (bus.mem_req && bus.mem_ack) req_cnt = 0;
      else if (bus.mem_req) req_cnt++;
      if (rst) begin
         m_cyc = 0; m_ir = 0; req_cnt = 0;
      end else begin
         m_cyc++;
         if (retire) m_ir++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic set_flags(input logic ld, st, br, jmp, rdw, tkn);
      is_load = ld; is_store = st; is_branch = br; is_jmp = jmp;
      rd_w = rdw; br_taken = tkn; illegal = 1'b0;
   endtask

   task automatic chk_counters(input string name);
`ifdef CORE_SEQ_PERF_EN
      chk({name, " cycle_cnt"}, cycle_cnt, m_cyc);
      chk({name, " instret_cnt"}, instret_cnt, m_ir);
`else
      chk({name, " cycle_cnt"}, cycle_cnt, 0);
      chk({name, " instret_cnt"}, instret_cnt, 0);
`endif
   endtask

   task automatic run_vec(input vec_t v);
      int n = 0, rf = 0, dreq = 0, dwe = 0, irw = 0, psel = 0, pcwe = 0;
      logic done = 1'b0;
      vec_t e;
      set_flags(v.ld, v.st, v.br, v.jmp, v.rdw, v.tkn);
      fw_cur = v.fw; mw_cur = v.mw; stray_cur = v.stray;
      sb.push_back(v);
      for (int k = 0; k < 40 && !done; k++) begin
         cyc();
         if (s_state != 3'd0) n++;
         rf   += int'(s_rfwe);
         dreq += int'(s_req & s_data);
         dwe  += int'(s_req & s_we);
         irw  += int'(s_irw);
         if (s_ret) begin
            done = 1'b1;
            psel = int'(s_psel);
            pcwe = int'(s_pcwe);
         end
      end
      chk({v.name, " retired"}, int'(done), 1);
      if (done && sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.name, " cycles"}, n, e.cyc);
         chk({e.name, " rf_we"}, rf, e.rf);
         chk({e.name, " pc_sel"}, psel, e.psel);
         chk({e.name, " pc_we"}, pcwe, 1);
         chk({e.name, " data req"}, dreq, e.dreq);
         chk({e.name, " data we"}, dwe, e.dwe);
         chk({e.name, " ir_we"}, irw, 1);
      end
      stray_cur = 1'b0;
   endtask

   initial begin
      int exp_st[6];
      int exp_rf[6];
      int cnt;
      bus.mem_ack = 1'b0;
      //          name        ld    st    br    jmp   rdw   tkn   stray fw mw cyc rf psel dreq dwe
      vecs[0] = '{"addi",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4, 1, 0, 0, 0};
      vecs[1] = '{"addi_fw2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 6, 1, 0, 0, 0};
      vecs[2] = '{"lw_mw3",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3, 8, 1, 0, 4, 0};
      vecs[3] = '{"lw_nord",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5, 0, 0, 1, 0};
      vecs[4] = '{"sw",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 1};
      vecs[5] = '{"sw_wait",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2, 7, 0, 0, 3, 3};
      vecs[6] = '{"beq_t",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3, 0, 1, 0, 0};
      vecs[7] = '{"beq_nt",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 0, 0};
      vecs[8] = '{"jal",      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 4, 1, 1, 0, 0};
      vecs[9] = '{"beq_stray",1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 4, 0, 1, 0, 0};

      // Reset state.
      do_reset();
      chk("reset state", state, 0);
      chk("reset mem_req", bus.mem_req, 0);
      chk("reset strobes", {ir_we, pc_we, pc_sel, rf_we, retire, halted}, 0);
      chk_counters("reset");

      // addi with immediate fetch ack: state trace 0,1,2,3,5,1.
      exp_st = '{0, 1, 2, 3, 5, 1};
      exp_rf = '{0, 0, 0, 0, 1, 0};
      set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      fw_cur = 0; mw_cur = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("addi trace state[%0d]", i), s_state, exp_st[i]);
         chk($sformatf("addi trace rf_we[%0d]", i), s_rfwe, exp_rf[i]);
         chk($sformatf("addi trace retire[%0d]", i), s_ret, exp_rf[i]);
      end

      // Table-driven instructions, back to back.
      do_reset();
      foreach (vecs[i]) run_vec(vecs[i]);
      chk("scoreboard empty", sb.size(), 0);
      chk_counters("after table");

      // halt_req at the retire boundary parks in IDLE until released.
      halt_req = 1'b1;
      run_vec(vecs[0]);
      chk("halt boundary state", state, 0);
      cyc();
      chk("halt idle hold state", state, 0);
      chk("halt idle mem_req", s_req, 0);
      halt_req = 1'b0;
      cyc();
      chk("halt release state", state, 1);

      // Illegal opcode in DECODE -> sticky HALT, no requests even with stray acks.
      set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      illegal = 1'b1;
      cyc();
      cyc();
      chk("illegal halt state", state, 7);
      chk("illegal halted", halted, 1);
      stray_cur = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         cnt += int'(s_req) + int'(s_state != 3'd7);
      end
      stray_cur = 1'b0;
      chk("halt 20 cycles quiet", cnt, 0);
      illegal = 1'b0;
      do_reset();
      chk("rst leaves halt", state, 0);
      chk("rst clears halted", halted, 0);

      // Load and store flags both set -> HALT.
      set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(); cyc(); cyc();
      chk("ld&st halt state", state, 7);
      do_reset();

      // Reset in the middle of a MEM wait abandons the request.
      set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      fw_cur = 0; mw_cur = 10;
      cnt = 0;
      while (state != 3'd4 && cnt < 20) begin
         cyc();
         cnt++;
      end
      chk("reached MEM", state, 4);
      cyc();
      chk("MEM wait req held", bus.mem_req, 1);
      rst = 1'b1;
      cyc();
      chk("rst in MEM state", state, 0);
      chk("rst in MEM mem_req", bus.mem_req, 0);
      chk("rst in MEM cycle_cnt", cycle_cnt, 0);
      chk("rst in MEM instret_cnt", instret_cnt, 0);
      rst = 1'b0;
      cyc();
      chk("post rst state", state, 1);
`ifdef CORE_SEQ_PERF_EN
      chk("post rst cycle_cnt", cycle_cnt, 1);
`else
      chk("post rst cycle_cnt", cycle_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
